// File: rtl/hist_eq_pkg.sv
// Shared types and constants for the histogram-equalisation engine.
package hist_eq_pkg;

  // Frame sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_HIST  = 3'd2,
    ST_CDF   = 3'd3,
    ST_MAP   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Default geometry of the image datapath.
  localparam int PIX_W_DEF = 8;
  localparam int CNT_W_DEF = 18;
  localparam int BINS      = 2 ** PIX_W_DEF;
  localparam int BEAT_W    = CNT_W_DEF;

  // Ceiling log2, usable in constant expressions (0 for values <= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int p = 1; p < value; p = p * 2) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hist_eq_engine_lane_counter.sv
// Combinational per-bin match count of one LANES-wide beat.
// Every lane is compared against every bin, so lanes that collide on the
// same value all contribute to that bin's count.
module hist_lane_counter
  import hist_eq_pkg::*;
#(
  parameter  int LANES = 8,
  parameter  int PIX_W = 8,
  localparam int CW    = clog2(LANES) + 1,
  localparam int NB    = 2 ** PIX_W
) (
  input  logic [LANES*PIX_W-1:0] beat_data,
  output logic [NB*CW-1:0]       bin_count
);

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_bin
      logic [CW-1:0] cnt;

      // Count how many lanes of this beat carry the value of this bin.
      always_comb begin
        cnt = '0;
        for (int k = 0; k < LANES; k++) begin
          if (beat_data[k*PIX_W +: PIX_W] == PIX_W'(gi)) begin
            cnt = cnt + CW'(1);
          end
        end
      end

      assign bin_count[gi*CW +: CW] = cnt;
    end
  endgenerate

endmodule

// File: rtl/hist_eq_engine.sv
// Streaming histogram-equalisation engine: histogram pass, CDF-to-LUT
// pass, and a remap pass over the same frame.
module hist_eq_engine
  import hist_eq_pkg::*;
#(
  parameter int LANES = 8,
  parameter int PIX_W = 8,
  parameter int CNT_W = 18
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [4:0]             log2_pix,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*PIX_W-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*PIX_W-1:0] out_data,
  output logic                   busy,
  output logic                   done
);

  localparam int NUM_BINS   = 2 ** PIX_W;
  localparam int CW         = clog2(LANES) + 1;
  localparam int LOG2_LANES = clog2(LANES);
  localparam int PROD_W     = CNT_W + PIX_W;
  localparam logic [4:0] L_MIN = 5'(LOG2_LANES);
  localparam logic [4:0] L_MAX = 5'(CNT_W - 1);

  state_t state_reg, state_next;
  logic [4:0]             shift_reg;
  logic [4:0]             l_clamped;
  logic [CNT_W-1:0]       beat_cnt_reg;
  logic [CNT_W-1:0]       beats_total;
  logic                   last_in_reg;
  logic [PIX_W-1:0]       cdf_idx_reg;
  logic [CNT_W-1:0]       cdf_reg;
  logic [CNT_W-1:0]       cdf_next;
  logic [PROD_W-1:0]      cdf_prod;
  logic [PIX_W-1:0]       lut_value;
  logic                   out_valid_reg;
  logic [LANES*PIX_W-1:0] out_data_reg;
  logic [LANES*PIX_W-1:0] map_data;
  logic [NUM_BINS*CW-1:0] bin_count;
  logic                   accept;
  logic                   last_beat;
  logic                   out_take;

  logic [CNT_W-1:0] hist_reg [NUM_BINS];
  logic [CNT_W-1:0] hist_inc [NUM_BINS];
  logic [PIX_W-1:0] lut_reg  [NUM_BINS];

  hist_lane_counter #(
    .LANES(LANES),
    .PIX_W(PIX_W)
  ) u_lane_counter (
    .beat_data(in_data),
    .bin_count(bin_count)
  );

  // Clamp the requested frame size so a pass is at least one beat and a
  // bin can never overflow.
  always_comb begin
    if (log2_pix < L_MIN) begin
      l_clamped = L_MIN;
    end else if (log2_pix > L_MAX) begin
      l_clamped = L_MAX;
    end else begin
      l_clamped = log2_pix;
    end
  end

  assign beats_total = CNT_W'(1) << (shift_reg - L_MIN);
  assign last_beat   = (beat_cnt_reg == beats_total - CNT_W'(1));
  assign out_take    = out_valid_reg && out_ready;
  assign accept      = in_valid && in_ready;

  // Input acceptance: free-running in HIST, gated by the output register
  // in MAP, and closed once the whole remap pass has been taken in.
  always_comb begin
    in_ready = 1'b0;
    case (state_reg)
      ST_HIST: in_ready = 1'b1;
      ST_MAP:  in_ready = !last_in_reg && (!out_valid_reg || out_ready);
      default: in_ready = 1'b0;
    endcase
  end

  // Next-state logic for the frame sequencer.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_CLEAR;
      ST_CLEAR: state_next = ST_HIST;
      ST_HIST:  if (accept && last_beat) state_next = ST_CDF;
      ST_CDF:   if (cdf_idx_reg == PIX_W'(NUM_BINS - 1)) state_next = ST_MAP;
      ST_MAP:   if (last_in_reg && out_take) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Running CDF and its normalised LUT entry; the product is widened so
  // cdf*(BINS-1) never wraps before the shift by L.
  assign cdf_next  = cdf_reg + hist_reg[cdf_idx_reg];
  assign cdf_prod  = PROD_W'(cdf_next) * PROD_W'(NUM_BINS - 1);
  assign lut_value = PIX_W'(cdf_prod >> shift_reg);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BINS; gi++) begin : g_hist_inc
      assign hist_inc[gi] = hist_reg[gi] + CNT_W'(bin_count[gi*CW +: CW]);
    end
    for (gi = 0; gi < LANES; gi++) begin : g_map
      assign map_data[gi*PIX_W +: PIX_W] = lut_reg[in_data[gi*PIX_W +: PIX_W]];
    end
  endgenerate

  // Sequencer state, beat counting, CDF walk and the MAP output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      shift_reg     <= L_MIN;
      beat_cnt_reg  <= '0;
      last_in_reg   <= 1'b0;
      cdf_idx_reg   <= '0;
      cdf_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      state_reg <= state_next;

      if (state_reg == ST_IDLE && start) begin
        shift_reg <= l_clamped;
      end

      if (state_reg == ST_CLEAR) begin
        beat_cnt_reg <= '0;
        cdf_reg      <= '0;
        cdf_idx_reg  <= '0;
        last_in_reg  <= 1'b0;
      end else if (accept) begin
        beat_cnt_reg <= last_beat ? '0 : beat_cnt_reg + CNT_W'(1);
      end

      if (state_reg == ST_CDF) begin
        cdf_reg     <= cdf_next;
        cdf_idx_reg <= cdf_idx_reg + PIX_W'(1);
      end

      if (state_reg == ST_MAP && accept && last_beat) begin
        last_in_reg <= 1'b1;
      end else if (state_reg == ST_DONE) begin
        last_in_reg <= 1'b0;
      end

      if (state_reg == ST_MAP && accept) begin
        out_data_reg  <= map_data;
        out_valid_reg <= 1'b1;
      end else if (out_take) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  // Histogram bins: cleared together in CLEAR, bumped per accepted HIST beat.
  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_BINS; v++) begin
      if (state_reg == ST_CLEAR) begin
        hist_reg[v] <= '0;
      end else if (state_reg == ST_HIST && accept) begin
        hist_reg[v] <= hist_inc[v];
      end
    end
  end

  // Remap LUT: one entry written per CDF cycle.
  always_ff @(posedge clk) begin
    if (state_reg == ST_CDF) begin
      lut_reg[cdf_idx_reg] <= lut_value;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign done      = (state_reg == ST_DONE);

endmodule

// File: tb/tb_hist_eq_engine.sv
// Scoreboard bench for hist_eq_engine: a reference histogram/CDF model
// predicts every remapped beat, which is queued on input acceptance and
// compared when the DUT hands the beat over.
module tb_hist_eq_engine;

  localparam int LANES = 8;
  localparam int PIX_W = 8;
  localparam int CNT_W = 18;
  localparam int NB    = 256;
  localparam int DW    = LANES * PIX_W;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [4:0]    log2_pix;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  hist_eq_engine #(
    .LANES(LANES),
    .PIX_W(PIX_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .log2_pix(log2_pix),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .busy(busy),
    .done(done)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0]    pix_q[$];
  logic [DW-1:0] exp_q[$];
  int            lut_m[NB];
  int            bp_pat[4] = '{1, 0, 0, 1};

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int clamp_l(input int l2);
    if (l2 < 3) return 3;
    if (l2 > CNT_W - 1) return CNT_W - 1;
    return l2;
  endfunction

  function automatic logic [DW-1:0] beat_of(input int b);
    logic [DW-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*PIX_W +: PIX_W] = pix_q[b*LANES + k];
    return r;
  endfunction

  function automatic logic [DW-1:0] map_of(input int b);
    logic [DW-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*PIX_W +: PIX_W] = 8'(lut_m[pix_q[b*LANES + k]]);
    return r;
  endfunction

  // Reference: histogram of the frame, running CDF, lut = floor(cdf*255 / 2^L).
  task automatic build_model(input int L);
    int h[NB];
    int cdf;
    for (int i = 0; i < NB; i++) h[i] = 0;
    foreach (pix_q[i]) h[pix_q[i]]++;
    cdf = 0;
    for (int i = 0; i < NB; i++) begin
      cdf = cdf + h[i];
      lut_m[i] = (cdf * 255) >> L;
    end
  endtask

  task automatic run_frame(input string name, input int l2, input bit gaps,
                           input bit bp, input bit start_in_cdf);
    int L, B, sent, got, zeros, cyc, last_take;
    bit iv, ir, ov, orr, dn, stalled;
    logic [DW-1:0] od, held, exp;
    L = clamp_l(l2);
    B = (1 << L) / LANES;
    build_model(L);
    exp_q.delete();

    @(posedge clk); #1 start = 1'b1; log2_pix = 5'(l2);
    @(posedge clk); #1 start = 1'b0; log2_pix = 5'd0;
    @(negedge clk);
    check_val({name, " clear busy"}, busy, 1);
    check_val({name, " clear in_ready"}, in_ready, 0);
    @(posedge clk); #1;

    // HIST pass
    sent = 0; cyc = 0;
    while (sent < B && cyc < 4*B + 50) begin
      iv = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_valid = iv; in_data = beat_of(sent);
      @(negedge clk); ir = in_ready;
      if (cyc == 0) check_val({name, " hist in_ready"}, ir, 1);
      @(posedge clk);
      if (iv && ir) sent++;
      cyc++; #1;
    end
    in_valid = 1'b0;
    check_val({name, " hist beats"}, sent, B);

    // CDF pass: in_ready must stay low for exactly BINS cycles
    zeros = 0; ir = 1'b0;
    while (!ir && zeros < NB + 20) begin
      @(negedge clk); ir = in_ready;
      if (!ir) zeros++;
      @(posedge clk); #1;
      start = start_in_cdf && (zeros == 5);
    end
    start = 1'b0;
    check_val({name, " cdf cycles"}, zeros, NB);

    // MAP pass
    sent = 0; got = 0; cyc = 0; stalled = 1'b0; held = '0; dn = 1'b0; last_take = -10;
    while (!dn && cyc < 8*B + 50) begin
      iv = (sent < B) && (gaps ? ($urandom_range(0, 3) != 0) : 1'b1);
      in_valid = iv;
      in_data = (sent < B) ? beat_of(sent) : '0;
      orr = bp ? (bp_pat[cyc % 4] != 0) : 1'b1;
      out_ready = orr;
      @(negedge clk);
      ir = in_ready; ov = out_valid; od = out_data; dn = done;
      if (dn) begin
        check_val({name, " outputs before done"}, got, B);
        check_val({name, " done latency"}, last_take, cyc - 1);
      end else begin
        if (stalled) begin
          check_val({name, " stall valid"}, ov, 1);
          check_val({name, " stall data"}, od, held);
        end
        if (sent < B) check_val({name, " map in_ready"}, ir, !(ov && !orr));
      end
      @(posedge clk);
      if (ov && orr) begin
        if (exp_q.size() == 0) begin
          check_val({name, " unexpected beat"}, od, '1);
        end else begin
          exp = exp_q.pop_front();
          check_val({name, " map data"}, od, exp);
          $display("%s beat %0d data %h", name, got, od);
        end
        got++;
        last_take = cyc;
      end
      if (iv && ir) begin
        exp_q.push_back(map_of(sent));
        sent++;
      end
      stalled = ov && !orr;
      held = od;
      cyc++; #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check_val({name, " done seen"}, dn, 1);
    check_val({name, " scoreboard empty"}, exp_q.size(), 0);
    @(negedge clk);
    check_val({name, " done pulse width"}, done, 0);
    check_val({name, " idle busy"}, busy, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; log2_pix = '0;
    in_valid = 1'b1; in_data = '1; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_val("reset busy", busy, 0);
    check_val("reset in_ready", in_ready, 0);
    check_val("reset out_valid", out_valid, 0);
    check_val("reset done", done, 0);
    check_val("reset out_data", out_data, 0);
    #1 in_valid = 1'b0;

    // Uniform frame: each value once, L=8
    pix_q.delete();
    for (int i = 0; i < 256; i++) pix_q.push_back(8'(i));
    run_frame("uniform", 8, 1'b0, 1'b0, 1'b0);

    // Constant frame of 7s, L=10, bursty input, start pulsed during CDF
    pix_q.delete();
    for (int i = 0; i < 1024; i++) pix_q.push_back(8'd7);
    run_frame("constant", 10, 1'b1, 1'b0, 1'b1);

    // Lane collision: one beat of all 5s plus one beat of 0..7, with backpressure
    pix_q.delete();
    for (int i = 0; i < 8; i++) pix_q.push_back(8'd5);
    for (int i = 0; i < 8; i++) pix_q.push_back(8'(i));
    run_frame("collision", 4, 1'b0, 1'b1, 1'b0);

    // Random frame under backpressure and input gaps
    pix_q.delete();
    for (int i = 0; i < 256; i++) pix_q.push_back(8'($urandom_range(0, 255)));
    run_frame("backpressure", 8, 1'b1, 1'b1, 1'b0);

    // Clamp: log2_pix=1 forces L=3, one beat per pass
    pix_q.delete();
    for (int i = 0; i < 8; i++) pix_q.push_back(8'($urandom_range(0, 255)));
    run_frame("clamp", 1, 1'b0, 1'b0, 1'b0);

    // Reset during HIST after ten beats of 200s, then a clean frame
    @(posedge clk); #1 start = 1'b1; log2_pix = 5'd8;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 in_valid = 1'b1; in_data = {LANES{8'd200}};
    repeat (10) @(posedge clk);
    #1 reset = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_val("midreset busy", busy, 0);
    check_val("midreset in_ready", in_ready, 0);
    check_val("midreset out_valid", out_valid, 0);
    pix_q.delete();
    for (int i = 0; i < 256; i++) pix_q.push_back(8'($urandom_range(0, 150)));
    run_frame("after_reset", 8, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
